// File: rtl/pc_update_if.sv
// -----------------------------------------------------------------------------
// pc_update_if
// Bundles the decode/EX/hazard-side signals of the PC update unit.
//   master : the surrounding pipeline (drives requests, operands, flags,
//            hazards; receives the redirect result)
//   slave  : pc_update_unit itself
// Signals:
//   branch/call/ret     one-cycle request pulses from ID
//   pc_plus1            address after the control instruction
//   offset              signed branch displacement relative to pc_plus1
//   call_target         absolute call destination
//   cond                branch condition code
//   flags               {Z,V,N} from EX
//   flags_valid         flags reflect all older instructions
//   data_hazard         operand hazard pending
//   PC_update           one-cycle strobe, new_pc valid
//   new_pc              redirected PC (holds last value)
//   taken               redirect departs from sequential flow
//   busy                unit is not idle
//   ras_err             sticky return-stack underflow
// -----------------------------------------------------------------------------
interface pc_update_if #(
    parameter int PC_WIDTH = 16
);
    logic                branch;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] offset;
    logic [PC_WIDTH-1:0] call_target;
    logic [2:0]          cond;
    logic [2:0]          flags;
    logic                flags_valid;
    logic                data_hazard;
    logic                PC_update;
    logic [PC_WIDTH-1:0] new_pc;
    logic                taken;
    logic                busy;
    logic                ras_err;

    modport master (
        output branch, call, ret, pc_plus1, offset, call_target, cond,
               flags, flags_valid, data_hazard,
        input  PC_update, new_pc, taken, busy, ras_err
    );

    modport slave (
        input  branch, call, ret, pc_plus1, offset, call_target, cond,
               flags, flags_valid, data_hazard,
        output PC_update, new_pc, taken, busy, ras_err
    );
endinterface

// File: rtl/pc_update_unit.sv
// -----------------------------------------------------------------------------
// pc_update_unit
// Resolves conditional branches, calls and returns and produces the
// redirected PC with a one-cycle PC_update strobe. Waits out pending
// flag/operand hazards before resolving. Calls and returns use a circular
// return-address stack that silently overwrites its oldest entry when full
// and flags underflow through the sticky ras_err output.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset (also empties the return stack)
//   bus  pc_update_if slave modport (requests in, redirect result out)
// -----------------------------------------------------------------------------
module pc_update_unit #(
    parameter int PC_WIDTH  = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    pc_update_if.slave     bus
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_BRANCH = 2'd0,
        K_CALL   = 2'd1,
        K_RET    = 2'd2
    } kind_t;

    // Condition-code evaluation on flags {Z,V,N}; signed compares use N^V.
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        logic lt;
        logic res;
        z  = f[2];
        v  = f[1];
        n  = f[0];
        lt = n ^ v;
        case (c)
            3'd0:    res = ~z;
            3'd1:    res = z;
            3'd2:    res = ~z & ~lt;
            3'd3:    res = lt;
            3'd4:    res = ~lt;
            3'd5:    res = z | lt;
            3'd6:    res = v;
            3'd7:    res = 1'b1;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    state_t              r_state;
    kind_t               r_kind;
    logic [PC_WIDTH-1:0] r_pc_plus1;
    logic [PC_WIDTH-1:0] r_offset;
    logic [PC_WIDTH-1:0] r_call_target;
    logic [2:0]          r_cond;

    logic                r_pc_update;
    logic [PC_WIDTH-1:0] r_new_pc;
    logic                r_taken;
    logic                r_busy;
    logic                r_ras_err;

    logic [PC_WIDTH-1:0] r_ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    r_ras_ptr;
    logic [CNT_W-1:0]    r_ras_cnt;

    logic                w_req_any;
    kind_t               w_req_kind;
    logic                w_req_hazard;
    logic                w_hold_hazard;
    logic                w_cond_met;
    logic [PTR_W-1:0]    w_ras_ptr_dec;
    logic [PC_WIDTH-1:0] w_branch_target;

    // Request arbitration: ret beats call beats branch.
    always_comb begin
        w_req_any  = bus.ret | bus.call | bus.branch;
        w_req_kind = K_BRANCH;
        if (bus.ret) begin
            w_req_kind = K_RET;
        end else if (bus.call) begin
            w_req_kind = K_CALL;
        end else begin
            w_req_kind = K_BRANCH;
        end
    end

    // Hazard for a new request and for the held request: branches wait on
    // flags, calls/returns wait on operands.
    always_comb begin
        w_req_hazard  = 1'b0;
        w_hold_hazard = 1'b0;
        if (w_req_kind == K_BRANCH) begin
            w_req_hazard = ~bus.flags_valid;
        end else begin
            w_req_hazard = bus.data_hazard;
        end
        if (r_kind == K_BRANCH) begin
            w_hold_hazard = ~bus.flags_valid;
        end else begin
            w_hold_hazard = bus.data_hazard;
        end
    end

    // Target arithmetic; branch target wraps modulo 2^PC_WIDTH.
    always_comb begin
        w_cond_met      = cond_met(r_cond, bus.flags);
        w_ras_ptr_dec   = r_ras_ptr - PTR_W'(1);
        w_branch_target = r_pc_plus1 + r_offset;
    end

    // Control FSM, holding registers, registered outputs and return stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_kind        <= K_BRANCH;
            r_pc_plus1    <= {PC_WIDTH{1'b0}};
            r_offset      <= {PC_WIDTH{1'b0}};
            r_call_target <= {PC_WIDTH{1'b0}};
            r_cond        <= 3'd0;
            r_pc_update   <= 1'b0;
            r_new_pc      <= {PC_WIDTH{1'b0}};
            r_taken       <= 1'b0;
            r_busy        <= 1'b0;
            r_ras_err     <= 1'b0;
            r_ras_ptr     <= {PTR_W{1'b0}};
            r_ras_cnt     <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pc_update <= 1'b0;
                    if (w_req_any) begin
                        r_kind        <= w_req_kind;
                        r_pc_plus1    <= bus.pc_plus1;
                        r_offset      <= bus.offset;
                        r_call_target <= bus.call_target;
                        r_cond        <= bus.cond;
                        r_busy        <= 1'b1;
                        r_state       <= w_req_hazard ? S_WAIT : S_RESOLVE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    r_busy  <= 1'b1;
                    r_state <= w_hold_hazard ? S_WAIT : S_RESOLVE;
                end
                S_RESOLVE: begin
                    case (r_kind)
                        K_BRANCH: begin
                            r_new_pc <= w_cond_met ? w_branch_target : r_pc_plus1;
                            r_taken  <= w_cond_met;
                        end
                        K_CALL: begin
                            r_ras_mem[r_ras_ptr] <= r_pc_plus1;
                            r_ras_ptr            <= r_ras_ptr + PTR_W'(1);
                            if (r_ras_cnt != RAS_FULL) begin
                                r_ras_cnt <= r_ras_cnt + CNT_W'(1);
                            end
                            r_new_pc <= r_call_target;
                            r_taken  <= 1'b1;
                        end
                        K_RET: begin
                            if (r_ras_cnt != {CNT_W{1'b0}}) begin
                                r_ras_ptr <= w_ras_ptr_dec;
                                r_ras_cnt <= r_ras_cnt - CNT_W'(1);
                                r_new_pc  <= r_ras_mem[w_ras_ptr_dec];
                                r_taken   <= 1'b1;
                            end else begin
                                r_new_pc  <= r_pc_plus1;
                                r_taken   <= 1'b0;
                                r_ras_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_new_pc <= r_pc_plus1;
                            r_taken  <= 1'b0;
                        end
                    endcase
                    r_busy      <= 1'b1;
                    r_pc_update <= 1'b1;
                    r_state     <= S_UPDATE;
                end
                S_UPDATE: begin
                    // Requests seen here are dropped; the strobe lasts one cycle.
                    r_pc_update <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_pc_update <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PC_update = r_pc_update;
    assign bus.new_pc    = r_new_pc;
    assign bus.taken     = r_taken;
    assign bus.busy      = r_busy;
    assign bus.ras_err   = r_ras_err;

endmodule
